pdu_run_ctrl: RTL and testbench
===============================

# pdu_run_ctrl

Parametrised run-control and debug engine for the PDU: generates the gated CPU clock, enforces up to NUM_BP hardware breakpoints, supports single-step, waits for user input when the CPU polls the switch-available port, and walks a check address for memory/register inspection. It sits between the debounced button pulses and the CPU's clock and debug bus, and supersedes the fixed single-breakpoint run logic.

## Interface
Parameters:
- NUM_BP, 4, number of breakpoint slots (1..16)
- DIV_N, 5, clk cycles per clk_cpu half-period (>=1)
- CHK_W, 16, check-address width
- SW_AVAIL_ADDR, 16'hFF10, io_addr whose read enters input-wait

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- btn_cont / btn_step / btn_chk_l / btn_chk_r / btn_data  in  1 each  debounced single-cycle pulses
- bp_we  in  1  write one breakpoint slot
- bp_idx  in  $clog2(NUM_BP) (min 1)  slot index
- bp_set  in  1  1 = arm slot with bp_addr, 0 = disarm
- bp_addr  in  32  breakpoint PC
- chk_base  in  CHK_W  value loaded into chk_addr on debug entry
- current_pc  in  32  CPU PC
- io_addr  in  16, io_rd  in  1  CPU IO bus
- clk_cpu  out  1  gated CPU clock
- cpu_stop  out  1  high while CPU is halted
- chk_addr  out  CHK_W  current inspection address
- bp_hit  out  1, bp_hit_idx  out  $clog2(NUM_BP)  last halt cause
- wait_input  out  1  high in WAIT_IN
- state  out  3  encoded FSM state

## Operation
- States: STOP=0, RUN=1, WAIT_IN=2, STEP=3, DEBUG=4.
- STOP: btn_cont -> RUN; btn_step -> STEP; btn_chk_l or btn_chk_r -> DEBUG (chk_addr <= chk_base).
- DEBUG: btn_chk_r -> chk_addr+1, btn_chk_l -> chk_addr-1 (mod 2^CHK_W, wraps); btn_cont -> RUN; btn_step -> STEP.
- RUN: io_rd && io_addr==SW_AVAIL_ADDR -> WAIT_IN; at a CPU-cycle boundary with breakpoint match -> STOP.
- WAIT_IN: clock keeps running; btn_data -> RUN; breakpoint match at boundary -> STOP.
- STEP: exactly one full clk_cpu period, then STOP; breakpoints ignored.
- Breakpoint match: any armed slot == current_pc; lowest index wins; sets bp_hit=1, bp_hit_idx. bp_hit cleared on leaving STOP.
- Resume skip: the first CPU cycle after entering RUN does not evaluate breakpoints, so resuming from a breakpoint PC advances.
- Simultaneous button pulses priority: cont > step > chk_r > chk_l. Breakpoint beats io-read in same cycle.
- bp_we is accepted in any state; takes effect next cycle.

## Timing
- Reset values: state=STOP, clk_cpu=0, cpu_stop=1, chk_addr=0, bp_hit=0, bp_hit_idx=0, wait_input=0, divider counter=0, all slots disarmed.
- CPU period = 2*DIV_N clk cycles: clk_cpu high for counts 0..DIV_N-1, low for DIV_N..2*DIV_N-1. Boundary = count 2*DIV_N-1.
- Halt only at a boundary: a started period always completes; clk_cpu never emits a runt pulse.
- clk_cpu first rising edge one clk after entering RUN/STEP.
- Button -> state change: 1 clk. chk_addr updates 1 clk after the pulse.
- rst mid-period: clk_cpu forced low next edge, counter cleared.

## Configuration
- PDU_STEP_EN defined: STEP state and btn_step active as above.
- Undefined: btn_step ignored, STEP never entered, state encoding unchanged (value 3 unused).

## Structure
- Shared package pdu_pkg: state enum/localparams, SW_AVAIL_ADDR default, priority constants.
- Sub-module pdu_clk_gate: divider counter, clk_cpu generation, boundary pulse, run/halt request input; FSM stays in top.

## Test plan
- Reset then btn_cont, DIV_N=5 -> clk_cpu first high 1 clk later, period 10 clk, cpu_stop=0.
- Arm slot 2 at 0x0000_0040, run PC sequence 0x3C,0x40 -> STOP at that boundary, bp_hit=1, bp_hit_idx=2; btn_cont -> PC 0x44 reached without re-halt.
- Slots 0 and 3 both 0x80 -> halt with bp_hit_idx=0.
- io_rd with io_addr=16'hFF10 in RUN -> WAIT_IN, wait_input=1; btn_data -> RUN.
- DEBUG with chk_base=16'h0000, btn_chk_l -> chk_addr=16'hFFFF; btn_chk_r twice -> 16'h0001.
- With PDU_STEP_EN, btn_step in STOP -> exactly one clk_cpu pulse then STOP; without macro -> no pulse.

Source files
------------

// File: rtl/pdu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pdu_pkg                                                              |
// | Shared run-control types: FSM state encoding, button arbitration.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pdu_pkg;

  typedef enum logic [2:0] {
    ST_STOP    = 3'd0,
    ST_RUN     = 3'd1,
    ST_WAIT_IN = 3'd2,
    ST_STEP    = 3'd3,
    ST_DEBUG   = 3'd4
  } pdu_state_e;

  localparam logic [15:0] SW_AVAIL_ADDR_DEF = 16'hFF10;

  // Enum order doubles as the button priority: cont > step > chk_r > chk_l.
  typedef enum logic [2:0] {
    BTN_NONE  = 3'd0,
    BTN_CONT  = 3'd1,
    BTN_STEP  = 3'd2,
    BTN_CHK_R = 3'd3,
    BTN_CHK_L = 3'd4
  } pdu_btn_e;

  function automatic pdu_btn_e btn_select(input logic cont, input logic step,
                                          input logic chk_r, input logic chk_l);
    if (cont)       return BTN_CONT;
    else if (step)  return BTN_STEP;
    else if (chk_r) return BTN_CHK_R;
    else if (chk_l) return BTN_CHK_L;
    else            return BTN_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pdu_clk_gate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pdu_clk_gate                                                         |
// | CPU clock divider: whole periods only, boundary pulse on last count. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pdu_clk_gate #(
  parameter int DIV_N = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic halt_i,
  output logic clk_cpu_o,
  output logic boundary_o
);

  localparam int CNT_W = (2 * DIV_N > 2) ? $clog2(2 * DIV_N) : 1;
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(2 * DIV_N - 1);
  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(DIV_N - 1);

  logic             act_q, act_d;
  logic             clk_q, clk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A started period always runs to LAST; only there may the clock stop.
  always_comb begin
    act_d = act_q;
    clk_d = clk_q;
    cnt_d = cnt_q;
    if (!act_q) begin
      if (run_i) begin
        act_d = 1'b1;
        cnt_d = '0;
        clk_d = 1'b1;
      end
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      if (run_i && !halt_i) begin
        clk_d = 1'b1;
      end else begin
        act_d = 1'b0;
        clk_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      clk_d = (cnt_q < HIGH_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q <= 1'b0;
      clk_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      act_q <= act_d;
      clk_q <= clk_d;
      cnt_q <= cnt_d;
    end
  end

  assign clk_cpu_o  = clk_q;
  assign boundary_o = act_q && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/pdu_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pdu_run_ctrl                                                         |
// | PDU run/debug engine: breakpoints, input-wait, inspection address.   |
// | Define PDU_STEP_EN to enable single-step (btn_step / STEP state).    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pdu_run_ctrl
  import pdu_pkg::*;
#(
  parameter int          NUM_BP        = 4,
  parameter int          DIV_N         = 5,
  parameter int          CHK_W         = 16,
  parameter logic [15:0] SW_AVAIL_ADDR = SW_AVAIL_ADDR_DEF
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        btn_cont,
  input  logic                                        btn_step,
  input  logic                                        btn_chk_l,
  input  logic                                        btn_chk_r,
  input  logic                                        btn_data,
  input  logic                                        bp_we,
  input  logic [((NUM_BP > 1) ? $clog2(NUM_BP) : 1)-1:0] bp_idx,
  input  logic                                        bp_set,
  input  logic [31:0]                                 bp_addr,
  input  logic [CHK_W-1:0]                            chk_base,
  input  logic [31:0]                                 current_pc,
  input  logic [15:0]                                 io_addr,
  input  logic                                        io_rd,
  output logic                                        clk_cpu,
  output logic                                        cpu_stop,
  output logic [CHK_W-1:0]                            chk_addr,
  output logic                                        bp_hit,
  output logic [((NUM_BP > 1) ? $clog2(NUM_BP) : 1)-1:0] bp_hit_idx,
  output logic                                        wait_input,
  output logic [2:0]                                  state
);

  localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

  pdu_state_e        state_q;
  logic              skip_q;
  logic              bp_hit_q;
  logic [IDX_W-1:0]  bp_hit_idx_q;
  logic [CHK_W-1:0]  chk_addr_q;
  logic [NUM_BP-1:0] bp_valid_q;
  logic [31:0]       bp_addr_q [NUM_BP];

  logic              w_step;
  logic              w_boundary;
  logic              w_running;
  logic              w_bp_match;
  logic [IDX_W-1:0]  w_bp_idx;
  logic              w_bp_halt;
  logic              w_halt;
  pdu_btn_e          w_btn;

`ifdef PDU_STEP_EN
  assign w_step = btn_step;
`else
  logic w_unused_step;
  assign w_unused_step = btn_step;
  assign w_step        = 1'b0;
`endif

  assign w_btn = btn_select(btn_cont, w_step, btn_chk_r, btn_chk_l);

  always_ff @(posedge clk) begin
    if (rst) begin
      bp_valid_q <= '0;
    end else if (bp_we && (int'(bp_idx) < NUM_BP)) begin
      bp_valid_q[bp_idx] <= bp_set;
      bp_addr_q[bp_idx]  <= bp_addr;
    end
  end

  // Scan high to low so the lowest matching slot is the one left standing.
  always_comb begin
    w_bp_match = 1'b0;
    w_bp_idx   = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_valid_q[i] && (bp_addr_q[i] == current_pc)) begin
        w_bp_match = 1'b1;
        w_bp_idx   = IDX_W'(i);
      end
    end
  end

  assign w_running = (state_q == ST_RUN) || (state_q == ST_WAIT_IN) || (state_q == ST_STEP);
  assign w_bp_halt = w_boundary && w_bp_match && !skip_q &&
                     ((state_q == ST_RUN) || (state_q == ST_WAIT_IN));
  assign w_halt    = w_bp_halt || (w_boundary && (state_q == ST_STEP));

  pdu_clk_gate #(
    .DIV_N (DIV_N)
  ) u_clk_gate (
    .clk        (clk),
    .rst        (rst),
    .run_i      (w_running),
    .halt_i     (w_halt),
    .clk_cpu_o  (clk_cpu),
    .boundary_o (w_boundary)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_STOP;
      skip_q       <= 1'b0;
      bp_hit_q     <= 1'b0;
      bp_hit_idx_q <= '0;
      chk_addr_q   <= '0;
    end else begin
      case (state_q)
        ST_STOP, ST_DEBUG: begin
          case (w_btn)
            BTN_CONT: begin
              state_q  <= ST_RUN;
              skip_q   <= 1'b1;
              bp_hit_q <= 1'b0;
            end
            BTN_STEP: begin
              state_q  <= ST_STEP;
              bp_hit_q <= 1'b0;
            end
            BTN_CHK_R: begin
              state_q    <= ST_DEBUG;
              bp_hit_q   <= 1'b0;
              chk_addr_q <= (state_q == ST_STOP) ? chk_base : chk_addr_q + CHK_W'(1);
            end
            BTN_CHK_L: begin
              state_q    <= ST_DEBUG;
              bp_hit_q   <= 1'b0;
              chk_addr_q <= (state_q == ST_STOP) ? chk_base : chk_addr_q - CHK_W'(1);
            end
            default: ;
          endcase
        end
        ST_RUN, ST_WAIT_IN: begin
          // The first period after resuming never halts, so a breakpoint PC can retire.
          if (w_boundary) skip_q <= 1'b0;
          if (w_bp_halt) begin
            state_q      <= ST_STOP;
            bp_hit_q     <= 1'b1;
            bp_hit_idx_q <= w_bp_idx;
          end else if ((state_q == ST_RUN) && io_rd && (io_addr == SW_AVAIL_ADDR)) begin
            state_q <= ST_WAIT_IN;
          end else if ((state_q == ST_WAIT_IN) && btn_data) begin
            state_q <= ST_RUN;
          end
        end
        ST_STEP: begin
          if (w_boundary) state_q <= ST_STOP;
        end
        default: state_q <= ST_STOP;
      endcase
    end
  end

  assign cpu_stop   = (state_q == ST_STOP) || (state_q == ST_DEBUG);
  assign wait_input = (state_q == ST_WAIT_IN);
  assign state      = state_q;
  assign chk_addr   = chk_addr_q;
  assign bp_hit     = bp_hit_q;
  assign bp_hit_idx = bp_hit_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_pdu_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pdu_run_ctrl                                                      |
// | Directed bench: clock period, breakpoints, input-wait, step, debug.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pdu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_cont = 1'b0, btn_step = 1'b0, btn_chk_l = 1'b0, btn_chk_r = 1'b0, btn_data = 1'b0;
  logic        bp_we = 1'b0;
  logic [1:0]  bp_idx = '0;
  logic        bp_set = 1'b0;
  logic [31:0] bp_addr = '0;
  logic [15:0] chk_base = '0;
  logic [15:0] io_addr = '0;
  logic        io_rd = 1'b0;
  logic [31:0] pc_base = '0;
  logic [31:0] pc_off = '0;
  logic        pc_auto = 1'b1;
  wire  [31:0] current_pc = pc_base + pc_off;

  logic        clk_cpu, cpu_stop, bp_hit, wait_input;
  logic [15:0] chk_addr;
  logic [1:0]  bp_hit_idx;
  logic [2:0]  state;

  int n_chk = 0;
  int n_err = 0;

  pdu_run_ctrl #(
    .NUM_BP        (4),
    .DIV_N         (5),
    .CHK_W         (16),
    .SW_AVAIL_ADDR (16'hFF10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_cont   (btn_cont),
    .btn_step   (btn_step),
    .btn_chk_l  (btn_chk_l),
    .btn_chk_r  (btn_chk_r),
    .btn_data   (btn_data),
    .bp_we      (bp_we),
    .bp_idx     (bp_idx),
    .bp_set     (bp_set),
    .bp_addr    (bp_addr),
    .chk_base   (chk_base),
    .current_pc (current_pc),
    .io_addr    (io_addr),
    .io_rd      (io_rd),
    .clk_cpu    (clk_cpu),
    .cpu_stop   (cpu_stop),
    .chk_addr   (chk_addr),
    .bp_hit     (bp_hit),
    .bp_hit_idx (bp_hit_idx),
    .wait_input (wait_input),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Toy CPU: PC advances by one instruction on every clk_cpu rising edge.
  always @(posedge clk_cpu) if (pc_auto) pc_off <= pc_off + 32'd4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // m = {data, chk_l, chk_r, step, cont}
  task automatic press(input logic [4:0] m);
    btn_cont  = m[0];
    btn_step  = m[1];
    btn_chk_r = m[2];
    btn_chk_l = m[3];
    btn_data  = m[4];
    tick();
    {btn_cont, btn_step, btn_chk_r, btn_chk_l, btn_data} = '0;
  endtask

  task automatic arm(input logic [1:0] idx, input logic set, input logic [31:0] a);
    bp_we   = 1'b1;
    bp_idx  = idx;
    bp_set  = set;
    bp_addr = a;
    tick();
    bp_we   = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, output int n);
    n = 0;
    while ((state !== s) && (n < max)) begin
      tick();
      n++;
    end
  endtask

  task automatic sample_clk(input int len, output int highs, output int rises);
    logic prev;
    prev  = clk_cpu;
    highs = 0;
    rises = 0;
    for (int i = 0; i < len; i++) begin
      tick();
      if (clk_cpu) highs++;
      if (clk_cpu && !prev) rises++;
      prev = clk_cpu;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          n, hi, ri;
    logic [9:0]  pat;
    logic [31:0] tgt;

    pc_base = 32'h38;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_state", state, 3'd0);
    check("rst_clk_cpu", clk_cpu, 1'b0);
    check("rst_cpu_stop", cpu_stop, 1'b1);
    check("rst_chk_addr", chk_addr, 16'h0);
    check("rst_bp_hit", bp_hit, 1'b0);
    check("rst_bp_hit_idx", bp_hit_idx, 2'd0);
    check("rst_wait_input", wait_input, 1'b0);

    // Period shape and breakpoint at 0x40 (slot 2)
    arm(2'd2, 1'b1, 32'h40);
    press(5'b00001);
    check("run_state", state, 3'd1);
    check("run_cpu_stop", cpu_stop, 1'b0);
    check("run_clk_pre", clk_cpu, 1'b0);
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      pat[9-i] = clk_cpu;
    end
    check("clk_period_pattern", pat, 10'b1111100000);
    tick();
    check("clk_period_wrap", clk_cpu, 1'b1);
    check("pc_second_period", current_pc, 32'h40);
    wait_state(3'd0, 200, n);
    check("bp_halt_latency", n, 10);
    check("bp_hit", bp_hit, 1'b1);
    check("bp_hit_idx_2", bp_hit_idx, 2'd2);
    check("bp_cpu_stop", cpu_stop, 1'b1);
    check("bp_clk_low", clk_cpu, 1'b0);
    repeat (15) tick();
    check("halt_clk_quiet", clk_cpu, 1'b0);
    check("halt_pc_hold", current_pc, 32'h40);

    // Resume with PC frozen on the breakpoint: first boundary is skipped
    pc_auto = 1'b0;
    press(5'b00001);
    check("resume_bp_clear", bp_hit, 1'b0);
    wait_state(3'd0, 200, n);
    check("resume_skip_latency", n, 21);
    check("skip_rehalt_idx", bp_hit_idx, 2'd2);

    // Resume normally; lowest of two matching slots wins
    pc_auto = 1'b1;
    arm(2'd0, 1'b1, 32'h80);
    arm(2'd3, 1'b1, 32'h80);
    press(5'b00001);
    repeat (12) tick();
    check("advance_no_rehalt", state, 3'd1);
    check("advance_pc", current_pc, 32'h48);
    wait_state(3'd0, 400, n);
    check("dual_bp_state", state, 3'd0);
    check("dual_bp_idx", bp_hit_idx, 2'd0);
    check("dual_bp_pc", current_pc, 32'h80);

    // Input wait on switch-available read
    press(5'b00001);
    repeat (3) tick();
    io_rd = 1'b1; io_addr = 16'hFF11;
    tick();
    io_rd = 1'b0;
    check("io_wrong_addr", state, 3'd1);
    io_rd = 1'b1; io_addr = 16'hFF10;
    tick();
    io_rd = 1'b0;
    check("io_wait_state", state, 3'd2);
    check("io_wait_input", wait_input, 1'b1);
    check("io_wait_cpu_stop", cpu_stop, 1'b0);
    sample_clk(20, hi, ri);
    check("wait_clk_rises", ri, 2);
    check("wait_hold", state, 3'd2);
    press(5'b10000);
    check("data_resume", state, 3'd1);
    check("data_wait_clear", wait_input, 1'b0);

    tgt = current_pc + 32'd8;
    arm(2'd1, 1'b1, tgt);
    wait_state(3'd0, 100, n);
    check("bp1_state", state, 3'd0);
    check("bp1_idx", bp_hit_idx, 2'd1);
    check("bp1_pc", current_pc, tgt);

    // Single step
    press(5'b00010);
`ifdef PDU_STEP_EN
    check("step_enter", state, 3'd3);
    sample_clk(12, hi, ri);
    check("step_rises", ri, 1);
    check("step_highs", hi, 5);
    check("step_done", state, 3'd0);
`else
    check("step_ignored", state, 3'd0);
    sample_clk(12, hi, ri);
    check("step_rises", ri, 0);
    check("step_highs", hi, 0);
    check("step_done", state, 3'd0);
`endif

    // Debug walk with wrap
    chk_base = 16'h0000;
    press(5'b01000);
    check("dbg_enter", state, 3'd4);
    check("dbg_base_load", chk_addr, 16'h0000);
    check("dbg_bp_clear", bp_hit, 1'b0);
    check("dbg_cpu_stop", cpu_stop, 1'b1);
    press(5'b01000);
    check("dbg_wrap_down", chk_addr, 16'hFFFF);
    press(5'b00100);
    press(5'b00100);
    check("dbg_wrap_up", chk_addr, 16'h0001);
    chk_base = 16'h0055;
    press(5'b01100);
    check("dbg_r_beats_l", chk_addr, 16'h0002);
    press(5'b00101);
    check("dbg_cont_beats_chk", state, 3'd1);
    check("dbg_cont_chk_hold", chk_addr, 16'h0002);

    // Reset while clk_cpu is high
    n = 0;
    while (!clk_cpu && (n < 30)) begin
      tick();
      n++;
    end
    check("pre_rst_clk_high", clk_cpu, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_clk", clk_cpu, 1'b0);
    check("mid_rst_state", state, 3'd0);
    check("mid_rst_chk", chk_addr, 16'h0);
    tick();
    check("mid_rst_clk_stays", clk_cpu, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
